// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode map, widths,
// controller state encoding, FIFO entry layout and the result error rule.
package alu_pkg;

    localparam int OP_W    = 5;
    localparam int DATA_W  = 8;
    localparam int RES_W   = 16;
    localparam int ENTRY_W = 2 * DATA_W + OP_W;

    // Opcode map understood by the downstream ALU
    localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL    = 5'd2;
    localparam logic [OP_W-1:0] OP_DIV    = 5'd3;
    localparam logic [OP_W-1:0] OP_AND    = 5'd4;
    localparam logic [OP_W-1:0] OP_OR     = 5'd5;
    localparam logic [OP_W-1:0] OP_XOR    = 5'd6;
    localparam logic [OP_W-1:0] OP_NOT_A  = 5'd7;
    localparam logic [OP_W-1:0] OP_SHL    = 5'd8;
    localparam logic [OP_W-1:0] OP_SHR    = 5'd9;
    localparam logic [OP_W-1:0] OP_ROL    = 5'd10;
    localparam logic [OP_W-1:0] OP_ROR    = 5'd11;
    localparam logic [OP_W-1:0] OP_MOD    = 5'd12;
    localparam logic [OP_W-1:0] OP_INC_A  = 5'd13;
    localparam logic [OP_W-1:0] OP_DEC_A  = 5'd14;
    localparam logic [OP_W-1:0] OP_NEG_A  = 5'd15;
    localparam logic [OP_W-1:0] OP_PASS_A = 5'd16;
    localparam logic [OP_W-1:0] OP_PASS_B = 5'd17;
    localparam logic [OP_W-1:0] OP_MIN    = 5'd18;
    localparam logic [OP_W-1:0] OP_MAX    = 5'd19;
    localparam logic [OP_W-1:0] OP_EQ     = 5'd20;
    localparam logic [OP_W-1:0] OP_LT     = 5'd21;
    localparam logic [OP_W-1:0] OP_ABS_A  = 5'd22;
    localparam logic [OP_W-1:0] OP_ABS_B  = 5'd23;

    // Highest opcode the ALU implements; anything above is flagged
    localparam logic [OP_W-1:0] OP_LAST   = OP_ABS_B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One queued command, as stored in the FIFO (a in the MSBs)
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   cmd;
    } cmd_entry_t;

    // Result error: divide/modulo with a zero divisor, or an unknown opcode
    function automatic logic cmd_error(input logic [OP_W-1:0]   cmd,
                                       input logic [DATA_W-1:0] b);
        logic by_zero;
        logic bad_op;
        by_zero = ((cmd == OP_DIV) || (cmd == OP_MOD)) && (b == {DATA_W{1'b0}});
        bad_op  = (cmd > OP_LAST);
        return by_zero || bad_op;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issuer. Show-ahead read (rdata is the head entry),
// push ignored when full, pop ignored when empty, pointers wrap modulo DEPTH.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1,
    parameter int W     = ENTRY_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
    localparam logic [CW-1:0] CNT_STEP = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage: written at the tail on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Tail and head pointers, wrapping naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_STEP;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_STEP;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_STEP;
                2'b01:   count_r <= count_r - CNT_STEP;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: queues {a, b, opcode} commands, presents one at a time
// to an external ALU, enables its tri-state output for a single cycle,
// captures the result and holds it on a valid/ready result port.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_cmd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_command,
    output logic              alu_enable,
    input  logic [RES_W-1:0]  alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [OP_W-1:0]   res_cmd,
    output logic              res_err,
    output logic [CW-1:0]     count
);

    state_t            state_r;
    state_t            state_nxt_s;

    cmd_entry_t        wr_entry_s;
    cmd_entry_t        rd_entry_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic              push_s;
    logic              pop_s;
    logic              capture_s;
    logic              in_ready_s;

    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic [OP_W-1:0]   op_cmd_r;
    logic              alu_enable_r;
    logic              res_valid_r;
    logic [RES_W-1:0]  res_data_r;
    logic [OP_W-1:0]   res_cmd_r;
    logic              res_err_r;

    // Acceptance depends only on FIFO space, never on a same-cycle pop;
    // held low while reset is asserted.
    assign in_ready_s = !fifo_full_s && !rst;
    assign push_s     = in_valid && in_ready_s;
    assign wr_entry_s = {in_a, in_b, in_cmd};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (wr_entry_s),
        .pop   (pop_s),
        .rdata (rd_entry_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus pop/capture strobes; DONE pops straight into
    // ISSUE so a busy queue sustains one result every two cycles.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                capture_s   = 1'b1;
                state_nxt_s = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output strobes registered from the next state so they are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_enable_r <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            alu_enable_r <= (state_nxt_s == ISSUE);
            res_valid_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand registers: loaded from the FIFO head on every pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_r   <= {DATA_W{1'b0}};
            op_b_r   <= {DATA_W{1'b0}};
            op_cmd_r <= {OP_W{1'b0}};
        end else if (pop_s) begin
            op_a_r   <= rd_entry_s.a;
            op_b_r   <= rd_entry_s.b;
            op_cmd_r <= rd_entry_s.cmd;
        end
    end

    // Result capture: the ALU bus is only sampled while its output is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_r <= {RES_W{1'b0}};
            res_cmd_r  <= {OP_W{1'b0}};
            res_err_r  <= 1'b0;
        end else if (capture_s) begin
            res_data_r <= alu_y;
            res_cmd_r  <= op_cmd_r;
            res_err_r  <= cmd_error(op_cmd_r, op_b_r);
        end
    end

    assign in_ready    = in_ready_s;
    assign alu_a       = op_a_r;
    assign alu_b       = op_b_r;
    assign alu_command = op_cmd_r;
    assign alu_enable  = alu_enable_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_cmd     = res_cmd_r;
    assign res_err     = res_err_r;
    assign count       = fifo_count_s;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic [4:0]    in_cmd;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [4:0]    alu_command;
    logic          alu_enable;
    logic [15:0]   alu_y;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic [4:0]    res_cmd;
    logic          res_err;
    logic [CW-1:0] count;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  cmd;
        logic        err;
    } res_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [4:0]  cmd;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   prev_en  = 1'b0;
    res_t exp_q[$];
    int   res_times[$];

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cmd      (in_cmd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_command (alu_command),
        .alu_enable  (alu_enable),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_cmd     (res_cmd),
        .res_err     (res_err),
        .count       (count)
    );

    // Behavioural ALU used both to drive the bus and to predict results
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [4:0] c);
        int ia = int'(a);
        int ib = int'(b);
        case (c)
            5'd0:    return 16'(ia + ib);
            5'd1:    return 16'(ia - ib);
            5'd2:    return 16'(ia * ib);
            5'd3:    return (ib == 0) ? 16'hFFFF : 16'(ia / ib);
            5'd4:    return {8'h00, a & b};
            5'd5:    return {8'h00, a | b};
            5'd6:    return {8'h00, a ^ b};
            5'd12:   return (ib == 0) ? 16'hFFFF : 16'(ia % ib);
            5'd23:   return b[7] ? 16'(256 - ib) : 16'(ib);
            default: return (c <= 5'd23) ? {a, b ^ {3'b000, c}} : 16'h0000;
        endcase
    endfunction

    // Undriven bus shows up as a poison pattern so off-cycle sampling is visible
    assign alu_y = alu_enable ? alu_fn(alu_a, alu_b, alu_command) : 16'hBAD0;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [4:0] c);
        res_t r;
        r.data = alu_fn(a, b, c);
        r.cmd  = c;
        r.err  = ((c == 5'd3 || c == 5'd12) && b == 8'd0) || (c > 5'd23);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Push one command; caller sits just after a rising edge
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [4:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cmd = c;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_accepted", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for res_valid; returns on the falling edge where it is seen
    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, res_valid, 1'b1);
    endtask

    // Let every queued command complete and the block return to idle
    task automatic drain(input string name);
        int n = 0;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || res_valid || alu_enable || count != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_en = 1'b0;
            end else begin
                check("in_ready_eq_not_full", in_ready, (count != CW'(DEPTH)));
                check("count_bound", (count <= CW'(DEPTH)), 1'b1);
                if (prev_en) check("enable_single_cycle", alu_enable, 1'b0);
                prev_en = alu_enable;
                if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cmd));
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got result %0h expected none", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", res_data, e.data);
                        check("sb_cmd", res_cmd, e.cmd);
                        check("sb_err", res_err, e.err);
                    end
                    res_times.push_back(cyc);
                end
            end
        end
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[13];
        int   start;
        bit   push_done;
        vecs[0]  = '{8'd200, 8'd100, 5'd0,  16'd300,  1'b0};
        vecs[1]  = '{8'd50,  8'd0,   5'd3,  16'hFFFF, 1'b1};
        vecs[2]  = '{8'd7,   8'd9,   5'd30, 16'h0000, 1'b1};
        vecs[3]  = '{8'd100, 8'd7,   5'd3,  16'd14,   1'b0};
        vecs[4]  = '{8'd100, 8'd7,   5'd12, 16'd2,    1'b0};
        vecs[5]  = '{8'd17,  8'd0,   5'd12, 16'hFFFF, 1'b1};
        vecs[6]  = '{8'd5,   8'd10,  5'd1,  16'hFFFB, 1'b0};
        vecs[7]  = '{8'd1,   8'd1,   5'd24, 16'h0000, 1'b1};
        vecs[8]  = '{8'd0,   8'h80,  5'd23, 16'h0080, 1'b0};
        vecs[9]  = '{8'h0F,  8'h3C,  5'd4,  16'h000C, 1'b0};
        vecs[10] = '{8'd0,   8'd0,   5'd0,  16'h0000, 1'b0};
        vecs[11] = '{8'd9,   8'd0,   5'd23, 16'h0000, 1'b0};
        vecs[12] = '{8'd200, 8'd5,   5'd31, 16'h0000, 1'b1};

        rst = 1'b1;
        res_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd1;
        in_b = 8'd2;
        in_cmd = 5'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_alu_enable", alu_enable, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_alu_ops", {alu_a, alu_b, alu_command}, 0);
        check("rst_res", {res_data, res_cmd, res_err}, 0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check("release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // ADD 200+100: enable pulse one cycle, result two edges after push
        res_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 8'd200;
        in_b = 8'd100;
        in_cmd = OP_ADD;
        @(negedge clk);
        check("lat_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_e1_enable", alu_enable, 1'b0);
        check("lat_e1_valid", res_valid, 1'b0);
        check("lat_e1_count", count, 1);
        @(negedge clk);
        check("lat_e2_enable", alu_enable, 1'b1);
        check("lat_e2_valid", res_valid, 1'b0);
        @(negedge clk);
        check("lat_e3_enable", alu_enable, 1'b0);
        check("lat_e3_valid", res_valid, 1'b1);
        check("lat_e3_data", res_data, 16'd300);
        check("lat_e3_err", res_err, 1'b0);
        @(posedge clk);
        #1;
        drain("drain_latency");

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].cmd);
            wait_valid("tbl_valid");
            check("tbl_data", res_data, vecs[i].exp_data);
            check("tbl_cmd", res_cmd, vecs[i].cmd);
            check("tbl_err", res_err, vecs[i].exp_err);
            @(posedge clk);
            #1;
        end
        drain("drain_table");

        // Result held stable under back-pressure
        res_ready = 1'b0;
        push(8'd255, 8'd255, OP_MUL);
        wait_valid("hold_valid_seen");
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, 16'hFE01);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        drain("drain_hold");

        // Fill: one in DONE, four queued, sixth stalls until space frees
        start = res_times.size();
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(8'(k * 17 + 3), 8'(k + 1), 5'(k));
        @(negedge clk);
        check("full_res_valid", res_valid, 1'b1);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_a = 8'd99;
        in_b = 8'd33;
        in_cmd = OP_SUB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_count", count, 4);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("stall_release", in_ready, 1'b1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain("drain_full");
        check("full_result_count", res_times.size() - start, 6);

        // Reset while ISSUE with three queued commands
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) push(8'(k + 40), 8'(k + 2), OP_ADD);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("mid_issue_enable", alu_enable, 1'b1);
        check("mid_issue_count", count, 3);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_enable", alu_enable, 1'b0);
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_count", count, 0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("mid_release_in_ready", in_ready, 1'b1);
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", res_valid, 1'b0);
            check("post_rst_no_enable", alu_enable, 1'b0);
        end
        @(posedge clk);
        #1;

        // Ten back-to-back pushes: pointer wrap, one result every two cycles
        start = res_times.size();
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) push(8'($urandom), 8'($urandom_range(1, 255)), 5'(k));
        drain("drain_stream");
        check("stream_result_count", res_times.size() - start, 10);
        for (int k = start + 1; k < res_times.size(); k++) begin
            check("stream_spacing", res_times[k] - res_times[k-1], 2);
        end

        // Randomized traffic with random back-pressure
        push_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [7:0] rb;
                    rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                    push(8'($urandom), rb, 5'($urandom_range(0, 31)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    @(posedge clk);
                    #1 res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1, occupancy count width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  command offered.
REQ-006 in_ready  out  1  command FIFO can accept.
REQ-007 in_a, in_b  in  8 each  operands.
REQ-008 in_cmd  in  5  ALU opcode (ADD=0 ... ABS_B=23).
REQ-009 alu_a, alu_b  out  8 each  operands to ALU.
REQ-010 alu_command  out  5  opcode to ALU.
REQ-011 alu_enable  out  1  ALU output enable.
REQ-012 alu_y  in  16  ALU result, tri-stated when alu_enable=0.
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  result consumer accepts.
REQ-015 res_data  out  16  captured result.
REQ-016 res_cmd  out  5  opcode that produced res_data.
REQ-017 res_err  out  1  divide/modulo by zero, or opcode > 23.
REQ-018 count  out  CW  FIFO occupancy.

Function
REQ-019 Push SHALL occur on a clk edge with in_valid && in_ready, storing {in_a, in_b, in_cmd}.
REQ-020 in_ready SHALL equal !full, independent of same-cycle pop.
REQ-021 FSM states SHALL be IDLE, ISSUE, DONE.
REQ-022 IDLE: if count>0, pop head into operand regs, go to ISSUE; else stay.
REQ-023 ISSUE: alu_enable=1 for exactly one cycle; at the edge, capture alu_y -> res_data, opcode -> res_cmd, compute res_err; go to DONE.
REQ-024 alu_y SHALL be sampled only in ISSUE; never while alu_enable=0.
REQ-025 DONE: res_valid=1; res_data/res_cmd/res_err stable until res_ready.
REQ-026 DONE && res_ready: if count>0, pop and go to ISSUE (back-to-back); else go to IDLE.
REQ-027 Latency: res_valid asserts 2 edges after push edge into an empty, idle block.
REQ-028 Throughput SHALL be one result per 2 cycles under continuous res_ready.
REQ-029 res_err SHALL be 1 when (opcode==3 or 12) and operand b==0, or opcode>23; otherwise 0.
REQ-030 Results SHALL be returned in push order; no drops, no duplicates.
REQ-031 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-032 alu_a/alu_b/alu_command SHALL hold the operand regs in all states; alu_enable=0 outside ISSUE.

Reset
REQ-033 While rst=1: state IDLE, count=0, pointers 0, alu_enable=0, alu_a/alu_b/alu_command=0, res_valid=0, res_data=0, res_cmd=0, res_err=0, in_ready=0.
REQ-034 Reset mid-operation SHALL discard all queued and in-flight commands; in_ready=1 the first cycle after release.

Structure
REQ-035 Package alu_pkg SHALL hold the 24 opcode constants, opcode width 5, data widths 8/16, and the state enum.
REQ-036 FIFO SHALL be a sub-module alu_cmd_fifo (21-bit entries, DEPTH, push/pop/full/empty/count).

Verification
REQ-037 Push ADD a=200 b=100, res_ready=1 -> alu_enable high one cycle, res_valid 2 edges later, res_data=16'd300, res_err=0.
REQ-038 Push DIV a=50 b=0 -> res_data=16'hFFFF, res_cmd=3, res_err=1; opcode 30 -> res_data=0, res_err=1.
REQ-039 res_ready=0, push 6 ops -> 1 in DONE, count=4, in_ready=0, 6th stalls; release res_ready -> 5 results in order, then 6th accepted.
REQ-040 Hold res_ready=0 for 5 cycles on MUL a=255 b=255 -> res_valid stays 1, res_data=16'hFE01 stable.
REQ-041 Assert rst during ISSUE with count=3 -> immediately alu_enable=0, res_valid=0, count=0; no result after release.
REQ-042 Continuous 10 pushes with res_ready=1 -> pointer wrap, results every 2 cycles, order preserved.
